reset_sequencer: RTL and testbench

- Parametrised board-level reset generator that sits between the clock generator and the p1v core.
- Combines MMCM lock status with NUM_SRC external reset requests (RTS line, push buttons, ...), each configurable as level- or edge-triggered and active-high or active-low.
- Synchronises and debounces every source, then drives a stretched core reset with synchronous deassertion.
- Reports which source caused the last reset and counts resets.

---
 rtl/reset_sequencer_if.sv | 24 ++
 rtl/reset_sequencer.sv | 169 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Status/request bundle between the board-level reset sequencer and its
// surroundings. The sequencer is the master: it consumes lock and reset
// requests and drives the core reset plus diagnostic outputs.
interface reset_sequencer_if #(
    parameter int NUM_SRC = 2
);
    logic               locked;
    logic [NUM_SRC-1:0] src_in;
    logic               res;
    logic               resn;
    logic [NUM_SRC-1:0] cause;
    logic [7:0]         reset_count;
    logic [1:0]         state;

    modport master (
        input  locked, src_in,
        output res, resn, cause, reset_count, state
    );

    modport slave (
        output locked, src_in,
        input  res, resn, cause, reset_count, state
    );
endinterface

// File: rtl/reset_sequencer.sv
// Board-level reset generator. Synchronises MMCM lock and NUM_SRC external
// reset requests, debounces each request, and drives a stretched core reset
// that deasserts synchronously. Also reports the triggering source(s) and
// counts resets entered from RUN.
module reset_sequencer #(
    parameter int                 NUM_SRC         = 2,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 16,
    parameter int                 HOLD_CYCLES     = 1600,
    parameter logic [NUM_SRC-1:0] SRC_EDGE        = NUM_SRC'(2'b01),
    parameter logic [NUM_SRC-1:0] SRC_ACTIVE_LOW  = NUM_SRC'(2'b11)
) (
    input  logic              clock_160,
    input  logic              inp_resn,
    reset_sequencer_if.master bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic [NUM_SRC-1:0][SYNC_STAGES-1:0] src_sync_q;
    logic [SYNC_STAGES-1:0]              lock_sync_q;
    logic                                lock_ok;

    logic [NUM_SRC-1:0]                  sample;
    logic [NUM_SRC-1:0]                  db_q, db_d;
    logic [NUM_SRC-1:0][DEB_W-1:0]       db_cnt_q, db_cnt_d;
    logic [NUM_SRC-1:0]                  trig_q, trig_d;

    state_t                              state_q, state_d;
    logic [HOLD_W-1:0]                   hold_q, hold_d;
    logic [NUM_SRC-1:0]                  cause_q, cause_d;
    logic [7:0]                          count_q, count_d;
    logic                                res_q, resn_q, res_d;

    assign lock_ok = lock_sync_q[SYNC_STAGES-1];

    // Synchronisers; reset presets every source to its idle level and lock to "unlocked".
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            lock_sync_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                src_sync_q[i] <= {SYNC_STAGES{SRC_ACTIVE_LOW[i]}};
            end
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.locked};
            for (int i = 0; i < NUM_SRC; i++) begin
                src_sync_q[i] <= {src_sync_q[i][SYNC_STAGES-2:0], bus.src_in[i]};
            end
        end
    end

    // Polarity normalise, debounce, and derive the per-source trigger for the next cycle.
    always_comb begin
        sample   = '0;
        db_d     = db_q;
        db_cnt_d = '0;
        trig_d   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sample[i] = src_sync_q[i][SYNC_STAGES-1] ^ SRC_ACTIVE_LOW[i];
            if (sample[i] != db_q[i]) begin
                if (db_cnt_q[i] == DEB_LAST) begin
                    db_d[i] = sample[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            // Edge sources fire once on the accepted rise; level sources follow the filtered state.
            trig_d[i] = SRC_EDGE[i] ? (db_d[i] & ~db_q[i]) : db_d[i];
        end
    end

    // Debounce state, counters and registered triggers.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            db_q     <= '0;
            db_cnt_q <= '0;
            trig_q   <= '0;
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            trig_q   <= trig_d;
        end
    end

    // Sequencer next state: lock loss beats triggers; triggers (re)load the hold timer.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cause_d = cause_q;
        count_d = count_q;
        case (state_q)
            WAIT_LOCK: begin
                cause_d = '0;
                if (lock_ok) begin
                    state_d = HOLD;
                    hold_d  = HOLD_RELOAD;
                end
            end
            HOLD: begin
                if (!lock_ok) begin
                    state_d = WAIT_LOCK;
                    cause_d = '0;
                end else if (|trig_q) begin
                    // A held level source lands here every cycle, so HOLD never expires under it.
                    hold_d  = HOLD_RELOAD;
                    cause_d = cause_q | trig_q;
                end else if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            RUN: begin
                if (!lock_ok) begin
                    state_d = WAIT_LOCK;
                    cause_d = '0;
                end else if (|trig_q) begin
                    state_d = HOLD;
                    hold_d  = HOLD_RELOAD;
                    cause_d = trig_q;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cause_d = '0;
            end
        endcase
        res_d = (state_d != RUN);
    end

    // Sequencer state and registered outputs; resn has its own flop.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            state_q <= WAIT_LOCK;
            hold_q  <= '0;
            cause_q <= '0;
            count_q <= '0;
            res_q   <= 1'b1;
            resn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cause_q <= cause_d;
            count_q <= count_d;
            res_q   <= res_d;
            resn_q  <= ~res_d;
        end
    end

    assign bus.res         = res_q;
    assign bus.resn        = resn_q;
    assign bus.cause       = cause_q;
    assign bus.reset_count = count_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer. Stimulus pushes the expected output
// changes (cycle number and output values) into a queue; a monitor pops one
// entry every time the DUT outputs change and compares.
module tb_reset_sequencer;

    localparam int NUM_SRC = 2;
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic clock_160 = 1'b0;
    logic inp_resn  = 1'b1;
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    typedef struct {
        int          cyc;
        logic [12:0] vec;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    reset_sequencer_if #(.NUM_SRC(NUM_SRC)) bus ();

    reset_sequencer #(
        .NUM_SRC        (NUM_SRC),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .SRC_EDGE       (2'b01),
        .SRC_ACTIVE_LOW (2'b11)
    ) dut (
        .clock_160(clock_160),
        .inp_resn (inp_resn),
        .bus      (bus)
    );

    always #5 clock_160 = ~clock_160;

    always @(posedge clock_160) cyc <= cyc + 1;

    function automatic logic [12:0] pk(input logic r, input logic [1:0] s,
                                       input logic [1:0] c, input logic [7:0] n);
        return {r, s, c, n};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic expect_at(input int c, input logic r, input logic [1:0] s,
                             input logic [1:0] ca, input logic [7:0] n, input string nm);
        exp_t e;
        e.cyc  = c;
        e.vec  = pk(r, s, ca, n);
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock_160);
    endtask

    // Monitor: every change of the output bundle consumes one expectation.
    initial begin
        logic [12:0] prev;
        logic [12:0] cur;
        exp_t        e;
        prev = pk(1'b1, S_WAIT, 2'b00, 8'd0);
        forever begin
            @(negedge clock_160);
            cur = {bus.res, bus.state, bus.cause, bus.reset_count};
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: got %0h at cycle %0d, expected no change", cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_cycle"}, cyc, e.cyc);
                    check({e.name, "_outputs"}, {19'd0, cur}, {19'd0, e.vec});
                    check({e.name, "_resn"}, {31'd0, bus.resn}, {31'd0, ~e.vec[12]});
                end
                prev = cur;
            end
        end
    end

    // Stimulus
    initial begin
        int c;
        bus.locked = 1'b1;
        bus.src_in = 2'b11;
        #1 inp_resn = 1'b0;
        wait_cycles(3);

        check("rst_res",   {31'd0, bus.res},         32'd1);
        check("rst_resn",  {31'd0, bus.resn},        32'd0);
        check("rst_state", {30'd0, bus.state},       32'd0);
        check("rst_cause", {30'd0, bus.cause},       32'd0);
        check("rst_count", {24'd0, bus.reset_count}, 32'd0);

        // Power-up with lock already present
        c = cyc;
        expect_at(c + 3,  1'b1, S_HOLD, 2'b00, 8'd0, "pwr_hold");
        expect_at(c + 11, 1'b0, S_RUN,  2'b00, 8'd0, "pwr_run");
        inp_resn = 1'b1;
        wait_cycles(15);

        // Edge source held low: one reset, released while still low
        c = cyc;
        expect_at(c + 7,  1'b1, S_HOLD, 2'b01, 8'd1, "rts_hold");
        expect_at(c + 15, 1'b0, S_RUN,  2'b01, 8'd1, "rts_run");
        bus.src_in[0] = 1'b0;
        wait_cycles(40);
        bus.src_in[0] = 1'b1;
        wait_cycles(20);

        // 3-sample glitch is filtered, 4-sample pulse triggers
        bus.src_in[0] = 1'b0;
        wait_cycles(3);
        bus.src_in[0] = 1'b1;
        wait_cycles(12);
        c = cyc;
        expect_at(c + 7,  1'b1, S_HOLD, 2'b01, 8'd2, "pulse_hold");
        expect_at(c + 15, 1'b0, S_RUN,  2'b01, 8'd2, "pulse_run");
        bus.src_in[0] = 1'b0;
        wait_cycles(4);
        bus.src_in[0] = 1'b1;
        wait_cycles(30);

        // Level source pressed 30 cycles
        c = cyc;
        expect_at(c + 7,  1'b1, S_HOLD, 2'b10, 8'd3, "btn_hold");
        expect_at(c + 44, 1'b0, S_RUN,  2'b10, 8'd3, "btn_run");
        bus.src_in[1] = 1'b0;
        wait_cycles(30);
        bus.src_in[1] = 1'b1;
        wait_cycles(50);

        // Edge trigger during a HOLD started by the level source
        c = cyc;
        expect_at(c + 7,  1'b1, S_HOLD, 2'b10, 8'd4, "dbl_hold");
        expect_at(c + 17, 1'b1, S_HOLD, 2'b11, 8'd4, "dbl_cause");
        expect_at(c + 25, 1'b0, S_RUN,  2'b11, 8'd4, "dbl_run");
        bus.src_in[1] = 1'b0;
        wait_cycles(6);
        bus.src_in[1] = 1'b1;
        wait_cycles(4);
        bus.src_in[0] = 1'b0;
        wait_cycles(10);
        bus.src_in[0] = 1'b1;
        wait_cycles(30);

        // Lock loss in RUN and recovery
        c = cyc;
        expect_at(c + 3,  1'b1, S_WAIT, 2'b00, 8'd4, "lock_lost");
        expect_at(c + 13, 1'b1, S_HOLD, 2'b00, 8'd4, "lock_hold");
        expect_at(c + 21, 1'b0, S_RUN,  2'b00, 8'd4, "lock_run");
        bus.locked = 1'b0;
        wait_cycles(10);
        bus.locked = 1'b1;
        wait_cycles(25);

        // Asynchronous reset in the middle of HOLD
        c = cyc;
        expect_at(c + 7, 1'b1, S_HOLD, 2'b01, 8'd5, "hold_again");
        bus.src_in[0] = 1'b0;
        wait_cycles(6);
        bus.src_in[0] = 1'b1;
        wait_cycles(4);
        @(posedge clock_160);
        #2;
        expect_at(cyc, 1'b1, S_WAIT, 2'b00, 8'd0, "async_rst");
        inp_resn = 1'b0;
        #1;
        check("async_res",   {31'd0, bus.res},         32'd1);
        check("async_resn",  {31'd0, bus.resn},        32'd0);
        check("async_state", {30'd0, bus.state},       32'd0);
        check("async_cause", {30'd0, bus.cause},       32'd0);
        check("async_count", {24'd0, bus.reset_count}, 32'd0);
        wait_cycles(4);
        c = cyc;
        expect_at(c + 3,  1'b1, S_HOLD, 2'b00, 8'd0, "rel_hold");
        expect_at(c + 11, 1'b0, S_RUN,  2'b00, 8'd0, "rel_run");
        inp_resn = 1'b1;
        wait_cycles(20);

        check("pending_expectations", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
